// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// o_done is asserted combinationally during the final step together with the product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_active && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_product  = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_cnt    <= '0;
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in the result register one edge after accept;
// MUL (optional) runs through the iterative multiplier and holds off new input meanwhile.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [FLAG_W-1:0]  r_flags;
  logic               r_busy;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SH_W-1:0]    w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic [FLAG_W-1:0]  w_flags;
  logic [FLAG_W-1:0]  w_mul_flags;
  logic               w_is_mul;
  logic               w_in_fire;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_product;

  assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_in_fire = in_valid && in_ready;
  assign w_is_mul  = MUL_EN && (in_op == OP_MUL);

  assign w_sum   = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff  = {1'b0, in_a} - {1'b0, in_b};
  assign w_shamt = in_b[SH_W-1:0];

  // The extra top bit of w_diff is the unsigned borrow, shared by SUB and SLTU.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (in_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  w_res = in_a & in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_XOR:  w_res = in_a ^ in_b;
      OP_SLL:  w_res = in_a << w_shamt;
      OP_SRL:  w_res = in_a >> w_shamt;
      OP_SRA:  w_res = $signed(in_a) >>> w_shamt;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
        w_carry = w_diff[WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_flags              = '0;
    w_flags[FLAG_Z]      = (w_res == '0);
    w_flags[FLAG_N]      = w_res[WIDTH-1];
    w_flags[FLAG_C]      = w_carry;
    w_flags[FLAG_V]      = w_ovf;
    w_mul_flags          = '0;
    w_mul_flags[FLAG_Z]  = (w_mul_product == '0);
    w_mul_flags[FLAG_N]  = w_mul_product[WIDTH-1];
  end

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_in_fire && w_is_mul),
      .i_a       (in_a),
      .i_b       (in_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
    );
  end else begin : g_no_mul
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
  end

  // A load on the same edge as a consume overrides the clear, giving back-to-back results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            if (w_is_mul) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_result    <= w_res;
              r_flags     <= w_flags;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_result    <= w_mul_product;
            r_flags     <= w_mul_flags;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_zero   = r_flags[FLAG_Z];
  assign out_neg    = r_flags[FLAG_N];
  assign out_carry  = r_flags[FLAG_C];
  assign out_ovf    = r_flags[FLAG_V];
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, multi-cycle sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8, MUL enabled
  logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0] a8, b8, res8;
  logic [3:0] op8;
  logic       z8, n8, c8, v8;
  // WIDTH=8, MUL disabled
  logic       in_valid8n, in_ready8n, out_valid8n, out_ready8n, busy8n;
  logic [7:0] a8n, b8n, res8n;
  logic [3:0] op8n;
  logic       z8n, n8n, c8n, v8n;
  // WIDTH=64, MUL enabled
  logic        in_valid64, in_ready64, out_valid64, out_ready64, busy64;
  logic [63:0] a64, b64, res64;
  logic [3:0]  op64;
  logic        z64, n64, c64, v64;

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(a8), .in_b(b8), .in_op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(res8), .out_zero(z8), .out_neg(n8), .out_carry(c8), .out_ovf(v8),
    .busy(busy8)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut8n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8n), .in_ready(in_ready8n),
    .in_a(a8n), .in_b(b8n), .in_op(op8n), .out_valid(out_valid8n), .out_ready(out_ready8n),
    .out_result(res8n), .out_zero(z8n), .out_neg(n8n), .out_carry(c8n), .out_ovf(v8n),
    .busy(busy8n)
  );

  alu_pipe #(.WIDTH(64), .MUL_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_a(a64), .in_b(b64), .in_op(op64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_result(res64), .out_zero(z64), .out_neg(n64), .out_carry(c64), .out_ovf(v64),
    .busy(busy64)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed value of the low w bits of x.
  function automatic logic signed [65:0] sx(input logic [63:0] x, input int w);
    logic signed [65:0] t;
    t = $signed({2'b00, x});
    if (x[w-1]) t = t - (66'sd1 <<< w);
    return t;
  endfunction

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input bit mul_en, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t e;
    logic [63:0] mask, a, b;
    logic [64:0] s;
    logic signed [65:0] sa, sb, r, lim;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    sh   = int'(b % 64'(w));
    sa   = sx(a, w);
    sb   = sx(b, w);
    lim  = 66'sd1 <<< (w - 1);
    e    = '0;
    case (op)
      4'd0: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[63:0] & mask;
        e.c   = (s > {1'b0, mask});
        r     = sa + sb;
        e.v   = (r >= lim) || (r < -lim);
      end
      4'd1: begin
        e.res = (a - b) & mask;
        e.c   = (a < b);
        r     = sa - sb;
        e.v   = (r >= lim) || (r < -lim);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = (a << sh) & mask;
      4'd6: e.res = a >> sh;
      4'd7: begin
        r     = sa >>> sh;
        e.res = r[63:0] & mask;
      end
      4'd8: e.res = (sa < sb) ? 64'd1 : 64'd0;
      4'd9: begin
        e.res = (a < b) ? 64'd1 : 64'd0;
        e.c   = (a < b);
      end
      4'd10: e.res = mul_en ? ((a * b) & mask) : 64'd0;
      default: e.res = 64'd0;
    endcase
    e.z = (e.res == 64'd0);
    e.n = e.res[w-1];
    return e;
  endfunction

  // Scoreboards: accepted ops queue their model result; each delivered result pops one.
  exp_t q8[$];
  exp_t q64[$];

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          chk("mon8_unexpected_out", 68'(out_valid8), 68'(0));
        end else begin
          e = q8.pop_front();
          chk("mon8", 68'({res8, z8, n8, c8, v8}), 68'({e.res[7:0], e.z, e.n, e.c, e.v}));
        end
      end
      if (in_valid8 && in_ready8) q8.push_back(model(8, 1'b1, op8, 64'(a8), 64'(b8)));
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst_n) begin
      q64.delete();
    end else begin
      if (out_valid64 && out_ready64) begin
        if (q64.size() == 0) begin
          chk("mon64_unexpected_out", 68'(out_valid64), 68'(0));
        end else begin
          e = q64.pop_front();
          chk("mon64", 68'({res64, z64, n64, c64, v64}), 68'({e.res, e.z, e.n, e.c, e.v}));
        end
      end
      if (in_valid64 && in_ready64) q64.push_back(model(64, 1'b1, op64, a64, b64));
    end
  end

  task automatic rand8(input int n);
    int issued = 0;
    int guard  = 0;
    bit acc    = 1'b0;
    in_valid8 = 1'b0;
    while ((issued < n || in_valid8) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (in_valid8 && acc) in_valid8 = 1'b0;
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (!in_valid8 && issued < n && $urandom_range(0, 2) != 0) begin
        in_valid8 = 1'b1;
        op8 = 4'($urandom_range(0, 15));
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        issued++;
      end
      @(negedge clk);
      acc = in_valid8 && in_ready8;
    end
    chk("rand8_issue_bound", 68'(guard < 20000), 68'(1));
    out_ready8 = 1'b1;
    guard = 0;
    while (q8.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("rand8_drain", 68'(q8.size()), 68'(0));
  endtask

  task automatic rand64(input int n);
    int issued = 0;
    int guard  = 0;
    bit acc    = 1'b0;
    in_valid64 = 1'b0;
    while ((issued < n || in_valid64) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (in_valid64 && acc) in_valid64 = 1'b0;
      out_ready64 = ($urandom_range(0, 3) != 0);
      if (!in_valid64 && issued < n && $urandom_range(0, 2) != 0) begin
        in_valid64 = 1'b1;
        op64 = 4'($urandom_range(0, 15));
        a64  = {$urandom, $urandom};
        b64  = {$urandom, $urandom};
        issued++;
      end
      @(negedge clk);
      acc = in_valid64 && in_ready64;
    end
    chk("rand64_issue_bound", 68'(guard < 20000), 68'(1));
    out_ready64 = 1'b1;
    guard = 0;
    while (q64.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("rand64_drain", 68'(q64.size()), 68'(0));
  endtask

  vec_t vecs[16];
  logic [3:0] nm_ops[2];
  exp_t e_bp;
  int valid_seen;

  initial begin
    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{OP_ADD,  8'h05, 8'hFB, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_SRA,  8'h80, 8'h0B, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{OP_SLT,  8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SLTU, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_SLTU, 8'h01, 8'h80, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{OP_SLT,  8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_XOR,  8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_SLL,  8'h01, 8'h07, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_SRL,  8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd13,   8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'd15,   8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    nm_ops[0] = OP_MUL;
    nm_ops[1] = 4'd13;

    rst_n = 1'b0;
    in_valid8 = 1'b0;  a8 = '0;  b8 = '0;  op8 = '0;  out_ready8 = 1'b1;
    in_valid8n = 1'b0; a8n = '0; b8n = '0; op8n = '0; out_ready8n = 1'b1;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; op64 = '0; out_ready64 = 1'b1;

    // Reset state, sampled while reset is asserted and again after release.
    #1;
    chk("rst8_during", 68'({out_valid8, busy8, res8, z8, n8, c8, v8}), 68'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst8_after", 68'({out_valid8, busy8, in_ready8, res8, z8, n8, c8, v8}), 68'({1'b0, 1'b0, 1'b1, 12'h000}));
    chk("rst64_after", 68'({out_valid64, busy64, in_ready64, res64}), 68'({1'b0, 1'b0, 1'b1, 64'h0}));

    // Directed single-cycle vectors: result must be valid right after the accept edge.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid8 = 1'b1; op8 = vecs[i].op; a8 = vecs[i].a; b8 = vecs[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 68'(in_ready8), 68'(1));
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 68'(out_valid8), 68'(1));
      chk($sformatf("vec%0d_result", i), 68'({res8, z8, n8, c8, v8}),
          68'({vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v}));
    end

    // MUL: busy and in_ready=0 for WIDTH cycles, result exactly WIDTH cycles after accept.
    @(posedge clk); #1;
    in_valid8 = 1'b1; op8 = OP_MUL; a8 = 8'h0F; b8 = 8'h11;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("mul_wait%0d", k), 68'({busy8, in_ready8, out_valid8}), 68'({1'b1, 1'b0, 1'b0}));
      if (k < 7) @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("mul_done", 68'({out_valid8, busy8, res8, z8, n8, c8, v8}), 68'({1'b1, 1'b0, 8'hFF, 4'b0100}));

    // Reset in the middle of a multiply aborts it with no result.
    @(posedge clk); #1;
    in_valid8 = 1'b1; op8 = OP_MUL; a8 = 8'h03; b8 = 8'h05;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mulrst_during", 68'({busy8, out_valid8}), 68'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid8 || busy8) valid_seen++;
    end
    chk("mulrst_no_result", 68'(valid_seen), 68'(0));

    // MUL_EN=0: MUL and reserved opcodes both yield zero result, latency 1.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid8n = 1'b1; op8n = nm_ops[i]; a8n = 8'h0F; b8n = 8'h11;
      @(negedge clk);
      chk($sformatf("nomul%0d_in_ready", i), 68'(in_ready8n), 68'(1));
      @(posedge clk); #1;
      in_valid8n = 1'b0;
      @(negedge clk);
      chk($sformatf("nomul%0d_out", i), 68'({out_valid8n, busy8n, res8n, z8n, n8n, c8n, v8n}),
          68'({1'b1, 1'b0, 8'h00, 4'b1000}));
    end

    // Backpressure at WIDTH=64: held result stays stable and blocks input.
    @(posedge clk); #1;
    out_ready64 = 1'b0;
    in_valid64 = 1'b1; op64 = OP_ADD; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    e_bp = model(64, 1'b1, OP_ADD, a64, b64);
    @(posedge clk); #1;
    op64 = 4'($urandom_range(0, 9)); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), 68'({res64, z64, n64, c64, v64}), 68'({e_bp.res, e_bp.z, e_bp.n, e_bp.c, e_bp.v}));
      chk($sformatf("bp_block%0d", k), 68'({out_valid64, in_ready64}), 68'({1'b1, 1'b0}));
      @(posedge clk); #1;
    end
    out_ready64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d", k), 68'({in_ready64, out_valid64}), 68'({1'b1, 1'b1}));
      @(posedge clk); #1;
      if (k < 3) begin
        op64 = 4'($urandom_range(0, 9)); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      end else begin
        in_valid64 = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_last", 68'(out_valid64), 68'(1));
    @(negedge clk);
    chk("stream_empty", 68'({out_valid64, q64.size() == 0}), 68'({1'b0, 1'b1}));

    // Randomized traffic with random backpressure.
    rand8(300);
    rand64(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
